// File: rtl/apb_pkg.sv
// APB master bridge shared definitions:
// FSM encoding, transfer sizes and the alignment check.
package apb_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETUP  = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;
    localparam logic [1:0] ST_FAULT  = 2'd3;

    localparam logic [1:0] SIZE_BYTE  = 2'd0;
    localparam logic [1:0] SIZE_HALF  = 2'd1;
    localparam logic [1:0] SIZE_WORD  = 2'd2;
    localparam logic [1:0] SIZE_DWORD = 2'd3;

    function automatic int strb_width(input int data_w);
        return data_w / 8;
    endfunction

    // Too wide for the bus, or address not a multiple of the access size.
    function automatic logic is_misaligned(
        input logic [2:0] addr_lo,
        input logic [1:0] size,
        input logic [1:0] max_size
    );
        logic [2:0] mask;
        mask = 3'((4'd1 << size) - 4'd1);
        return (size > max_size) || ((addr_lo & mask) != 3'd0);
    endfunction

endpackage

// File: rtl/apb_lane_align.sv
// Byte-lane steering: write strobes, write data replication
// and right-aligned, zero-extended read data extraction.
module apb_lane_align #(
    parameter int DATA_W = 32
) (
    input  logic [1:0]                  wr_size,
    input  logic [$clog2(DATA_W/8)-1:0] wr_lane,
    input  logic                        wr_en,
    input  logic [DATA_W-1:0]           wdata,
    input  logic [1:0]                  rd_size,
    input  logic [$clog2(DATA_W/8)-1:0] rd_lane,
    input  logic [DATA_W-1:0]           prdata,
    output logic [DATA_W/8-1:0]         strb,
    output logic [DATA_W-1:0]           pwdata,
    output logic [DATA_W-1:0]           rdata
);

    localparam int STRB_W = DATA_W / 8;

    logic [3:0]        wr_nb;
    logic [3:0]        rd_nb;
    logic [DATA_W-1:0] shifted;

    always_comb begin
        wr_nb   = 4'd1 << wr_size;
        rd_nb   = 4'd1 << rd_size;
        shifted = prdata >> {rd_lane, 3'b000};
        strb    = '0;
        pwdata  = '0;
        rdata   = '0;
        for (int i = 0; i < STRB_W; i++) begin
            strb[i] = wr_en && (i >= int'(wr_lane))
                      && (i < int'(wr_lane) + int'(wr_nb));
            pwdata[8*i +: 8] = wdata[8*(i & (int'(wr_nb) - 1)) +: 8];
            rdata[8*i +: 8]  = (i < int'(rd_nb)) ? shifted[8*i +: 8] : 8'h00;
        end
    end

endmodule

// File: rtl/apb_master_bridge.sv
// APB4 master bridge: core valid/ready requests to APB transfers
// with lane steering, PSLVERR/timeout reporting and misalign faults.
module apb_master_bridge
    import apb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic                PCLK,
    input  logic                PRESETn,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_write,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [1:0]          req_size,
    input  logic [DATA_W-1:0]   req_wdata,
    output logic                rsp_valid,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err,
    output logic                PSEL,
    output logic                PENABLE,
    output logic                PWRITE,
    output logic [ADDR_W-1:0]   PADDR,
    output logic [DATA_W-1:0]   PWDATA,
    output logic [DATA_W/8-1:0] PSTRB,
    input  logic                PREADY,
    input  logic                PSLVERR,
    input  logic [DATA_W-1:0]   PRDATA
);

    localparam int STRB_W = strb_width(DATA_W);
    localparam int OFF_W  = $clog2(STRB_W);
    localparam int CNT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [1:0]       MAX_SIZE = 2'(OFF_W);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic [1:0]        size_q;
    logic [STRB_W-1:0] strb_q;
    logic [STRB_W-1:0] strb_nxt;
    logic [DATA_W-1:0] pwdata_nxt;
    logic [DATA_W-1:0] rdata_ext;
    logic [CNT_W-1:0]  wait_cnt;
    logic              accept;
    logic              misalign;
    logic              timed_out;
    logic              done;

    apb_lane_align #(.DATA_W(DATA_W)) u_align (
        .wr_size (req_size),
        .wr_lane (req_addr[OFF_W-1:0]),
        .wr_en   (req_write),
        .wdata   (req_wdata),
        .rd_size (size_q),
        .rd_lane (PADDR[OFF_W-1:0]),
        .prdata  (PRDATA),
        .strb    (strb_nxt),
        .pwdata  (pwdata_nxt),
        .rdata   (rdata_ext)
    );

    assign misalign  = is_misaligned(req_addr[2:0], req_size, MAX_SIZE);
    assign timed_out = (TIMEOUT > 0) && !PREADY && (wait_cnt == CNT_MAX);
    assign done      = (state == ST_ACCESS) && (PREADY || timed_out);
    assign req_ready = PRESETn && ((state == ST_IDLE) || (state == ST_FAULT) || done);
    assign accept    = req_valid && req_ready;
    assign PSEL      = (state == ST_SETUP) || (state == ST_ACCESS);
    assign PENABLE   = (state == ST_ACCESS);
    assign PSTRB     = PSEL ? strb_q : '0;

    always_comb begin
        case (state)
            ST_SETUP:  state_nxt = ST_ACCESS;
            ST_ACCESS: state_nxt = done ? ST_IDLE : ST_ACCESS;
            default:   state_nxt = ST_IDLE;
        endcase
        if (accept) state_nxt = misalign ? ST_FAULT : ST_SETUP;
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state     <= ST_IDLE;
            PADDR     <= '0;
            PWRITE    <= 1'b0;
            PWDATA    <= '0;
            strb_q    <= '0;
            size_q    <= '0;
            wait_cnt  <= '0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            state <= state_nxt;
            if (accept && !misalign) begin
                PADDR  <= req_addr;
                PWRITE <= req_write;
                PWDATA <= pwdata_nxt;
                strb_q <= strb_nxt;
                size_q <= req_size;
            end
            if (state == ST_SETUP) begin
                wait_cnt <= '0;
            end else if (state == ST_ACCESS && !PREADY && wait_cnt != CNT_MAX) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
            rsp_valid <= done || (state == ST_FAULT);
            // PSLVERR only counts on the PREADY cycle.
            rsp_err   <= (state == ST_FAULT) || timed_out || (done && PREADY && PSLVERR);
            rsp_rdata <= (done && PREADY && !PSLVERR && !PWRITE) ? rdata_ext : '0;
        end
    end

endmodule
